// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store funct3 encodings and the LSU state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load formatter: picks the byte/half/word addressed by lane out of
// a memory word and sign- or zero-extends it according to funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: validates the access, issues one req/ready
// transaction to data memory, formats load data and stalls the pipeline meanwhile.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              FaultM
);

  lsu_state_t        state, state_nxt;
  logic              access, fault, latch;
  logic              f3_ok, misalign;
  logic [1:0]        lane;
  logic [31:0]       fmt_wdata;
  logic [3:0]        fmt_wstrb;
  logic              req_we;
  logic [2:0]        req_f3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic [31:0]       load_data;

  assign access = MemReadM | MemWriteM;
  assign lane   = ALUResultM[1:0];

  always_comb begin
    if (MemReadM)
      f3_ok = (Funct3M == F3_B) || (Funct3M == F3_H) || (Funct3M == F3_W) ||
              (Funct3M == F3_BU) || (Funct3M == F3_HU);
    else
      f3_ok = (Funct3M == F3_B) || (Funct3M == F3_H) || (Funct3M == F3_W);
    misalign = ((Funct3M[1:0] == 2'b01) && lane[0]) ||
               ((Funct3M[1:0] == 2'b10) && (lane != 2'b00));
    fault    = (MemReadM & MemWriteM) | ~f3_ok | misalign;
  end

  // Store data is replicated across lanes so memory only needs the strobes.
  always_comb begin
    case (Funct3M[1:0])
      2'b00: begin
        fmt_wdata = {4{WriteDataM[7:0]}};
        fmt_wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        fmt_wdata = {2{WriteDataM[15:0]}};
        fmt_wstrb = 4'b0011 << lane;
      end
      default: begin
        fmt_wdata = WriteDataM;
        fmt_wstrb = 4'b1111;
      end
    endcase
    if (!MemWriteM) fmt_wstrb = 4'b0000;
  end

  always_comb begin
    state_nxt = state;
    StallM    = 1'b0;
    FaultM    = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (fault) begin
            FaultM = 1'b1;
          end else begin
            StallM    = 1'b1;
            latch     = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        StallM = 1'b1;
        if (mem_ready) state_nxt = DONE;
      end
      // DONE deliberately ignores the MEM inputs so the instruction is not re-issued.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_f3    <= 3'b000;
      req_addr  <= '0;
      req_wdata <= 32'h0;
      req_wstrb <= 4'h0;
      ReadDataM <= 32'h0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        req_we    <= MemWriteM;
        req_f3    <= Funct3M;
        req_addr  <= ALUResultM[ADDR_W-1:0];
        req_wdata <= fmt_wdata;
        req_wstrb <= fmt_wstrb;
      end
      if ((state == ACCESS) && mem_ready && !req_we)
        ReadDataM <= load_data;
    end
  end

  load_align u_load_align (
    .rdata  (mem_rdata),
    .funct3 (req_f3),
    .lane   (req_addr[1:0]),
    .result (load_data)
  );

  assign mem_req   = (state == ACCESS);
  assign mem_we    = req_we;
  assign mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = req_wdata;
  assign mem_wstrb = req_wstrb;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed table, randomized ops against
// an arithmetic reference model, and reset-during-access sequence.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] ReadDataM;
  logic        StallM, FaultM;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdm_model;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .ReadDataM(ReadDataM), .StallM(StallM), .FaultM(FaultM)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: rules expressed as plain arithmetic on sizes and lanes.
  function automatic bit m_fault(bit ld, bit st, bit [2:0] f3, bit [31:0] a);
    int size;
    if (ld && st) return 1'b1;
    if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b1;
    if (st && f3 > 2) return 1'b1;
    size = 1 << f3[1:0];
    return (a % size) != 0;
  endfunction

  function automatic bit [31:0] m_load(bit [2:0] f3, bit [31:0] a, bit [31:0] rd);
    bit [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return b + ((b >= 128) ? 32'hFFFFFF00 : 32'h0);
      3'd1:    return h + ((h >= 32768) ? 32'hFFFF0000 : 32'h0);
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit [3:0] m_strb(bit ld, bit [2:0] f3, bit [31:0] a);
    if (ld) return 4'd0;
    if (f3 == 0) return 4'(1 << (a % 4));
    if (f3 == 1) return 4'(3 << (a % 4));
    return 4'd15;
  endfunction

  function automatic bit [31:0] m_wdata(bit [2:0] f3, bit [31:0] wd);
    if (f3 == 0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  task automatic clear_inputs();
    MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
  endtask

  // Entered just after a posedge; leaves just after the posedge that ends the op.
  task automatic run_op(input string tag, input bit ld, input bit st, input bit [2:0] f3,
                        input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rd,
                        input int waits, input bit exp_fault, input bit [31:0] exp_rdm,
                        input bit [31:0] exp_addr, input bit [3:0] exp_strb,
                        input bit [31:0] exp_wdata);
    int stalls, rises, acc;
    bit prev_req, done;
    MemReadM = ld; MemWriteM = st; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    mem_ready = 0;
    @(negedge clk);
    if (!ld && !st) begin
      chk({tag, " idle_stall"}, StallM, 0);
      chk({tag, " idle_fault"}, FaultM, 0);
      chk({tag, " idle_req"}, mem_req, 0);
      chk({tag, " idle_rdata"}, ReadDataM, exp_rdm);
      @(posedge clk); #1;
      return;
    end
    if (exp_fault) begin
      chk({tag, " fault"}, FaultM, 1);
      chk({tag, " fault_stall"}, StallM, 0);
      chk({tag, " fault_req"}, mem_req, 0);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      chk({tag, " fault_after"}, FaultM, 0);
      chk({tag, " fault_req_after"}, mem_req, 0);
      chk({tag, " fault_rdata"}, ReadDataM, exp_rdm);
      @(posedge clk); #1;
      return;
    end
    chk({tag, " detect_fault"}, FaultM, 0);
    chk({tag, " detect_stall"}, StallM, 1);
    chk({tag, " detect_req"}, mem_req, 0);
    stalls = 1; rises = 0; acc = 0; prev_req = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      mem_ready = 0; mem_rdata = $urandom;
      @(negedge clk);
      if (mem_req && !prev_req) rises++;
      prev_req = mem_req;
      if (StallM) stalls++;
      if (mem_req) begin
        acc++;
        chk({tag, " addr"}, mem_addr, exp_addr);
        chk({tag, " we"}, mem_we, st);
        chk({tag, " strb"}, mem_wstrb, exp_strb);
        if (st) chk({tag, " wdata"}, mem_wdata, exp_wdata);
        if (acc == waits + 1) begin
          mem_ready = 1; mem_rdata = rd;
        end
      end else begin
        done = 1;
        chk({tag, " done_stall"}, StallM, 0);
        chk({tag, " done_fault"}, FaultM, 0);
        chk({tag, " done_rdata"}, ReadDataM, exp_rdm);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for DONE", tag);
    end
    chk({tag, " req_rises"}, rises, 1);
    chk({tag, " stall_cycles"}, stalls, waits + 2);
    @(posedge clk); #1;
    mem_ready = 0;
    clear_inputs();
  endtask

  typedef struct {
    bit ld; bit st; bit [2:0] f3; bit [31:0] a; bit [31:0] wd; bit [31:0] rd; int waits;
    bit flt; bit [31:0] rdm; bit [31:0] maddr; bit [3:0] strb; bit [31:0] wdat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit ld, st, flt;
    bit [2:0] f3;
    bit [31:0] a, wd, rd, exp_r;
    int kind, waits;

    tbl[0]  = '{1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 32'h100, 4'h0, 32'h0};
    tbl[1]  = '{1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 32'h100, 4'h0, 32'h0};
    tbl[2]  = '{1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 32'h00000080, 32'h100, 4'h0, 32'h0};
    tbl[3]  = '{0, 1, 3'b001, 32'h202, 32'hAAAA5678, 32'h0, 1, 0, 32'h00000080, 32'h200, 4'hC, 32'h56785678};
    tbl[4]  = '{1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 32'h00000080, 32'h0, 4'h0, 32'h0};
    tbl[5]  = '{0, 1, 3'b001, 32'h203, 32'h1234, 32'h0, 0, 1, 32'h00000080, 32'h0, 4'h0, 32'h0};
    tbl[6]  = '{1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 32'h00000080, 32'h0, 4'h0, 32'h0};
    tbl[7]  = '{1, 0, 3'b001, 32'h102, 32'h0, 32'h87654321, 1, 0, 32'hFFFF8765, 32'h100, 4'h0, 32'h0};
    tbl[8]  = '{1, 0, 3'b101, 32'h102, 32'h0, 32'h87654321, 0, 0, 32'h00008765, 32'h100, 4'h0, 32'h0};
    tbl[9]  = '{0, 1, 3'b000, 32'h101, 32'h123456AB, 32'h0, 0, 0, 32'h00008765, 32'h100, 4'h2, 32'hABABABAB};
    tbl[10] = '{0, 1, 3'b010, 32'h304, 32'hCAFEF00D, 32'h0, 3, 0, 32'h00008765, 32'h304, 4'hF, 32'hCAFEF00D};
    tbl[11] = '{1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 1, 32'h00008765, 32'h0, 4'h0, 32'h0};
    tbl[12] = '{0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1, 32'h00008765, 32'h0, 4'h0, 32'h0};
    tbl[13] = '{1, 0, 3'b000, 32'h100, 32'h0, 32'h0000007F, 0, 0, 32'h0000007F, 32'h100, 4'h0, 32'h0};

    clear_inputs();
    mem_ready = 0; mem_rdata = 0;
    reset = 1;
    @(negedge clk);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst ReadDataM", ReadDataM, 0);
    chk("rst StallM", StallM, 0);
    chk("rst FaultM", FaultM, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // Directed table; consecutive entries also exercise back-to-back issue.
    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd,
             tbl[i].rd, tbl[i].waits, tbl[i].flt, tbl[i].rdm, tbl[i].maddr, tbl[i].strb,
             tbl[i].wdat);
    rdm_model = 32'h0000007F;

    // Explicit SW followed immediately by LW.
    run_op("b2b_sw", 0, 1, 3'b010, 32'h400, 32'h11223344, 32'h0, 0, 0, rdm_model,
           32'h400, 4'hF, 32'h11223344);
    run_op("b2b_lw", 1, 0, 3'b010, 32'h400, 32'h0, 32'h11223344, 0, 0, 32'h11223344,
           32'h400, 4'h0, 32'h0);
    rdm_model = 32'h11223344;

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      ld = (kind == 1) || (kind >= 2 && kind <= 5);
      st = (kind == 1) || (kind >= 6);
      if ($urandom_range(0, 99) < 85) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = st ? 3'd0 : 3'd4;
          default: f3 = st ? 3'd1 : 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = 32'h1000 + $urandom_range(0, 255);
      if ($urandom_range(0, 99) < 70) a = a & ~((32'd1 << f3[1:0]) - 1);
      wd = $urandom; rd = $urandom;
      waits = $urandom_range(0, 3);
      flt = (ld || st) ? m_fault(ld, st, f3, a) : 1'b0;
      exp_r = rdm_model;
      if (ld && !flt) exp_r = m_load(f3, a, rd);
      run_op($sformatf("rnd%0d", n), ld, st, f3, a, wd, rd, waits, flt, exp_r,
             a & 32'hFFFFFFFC, m_strb(ld, f3, a), m_wdata(f3, wd));
      rdm_model = exp_r;
    end

    // Reset while ACCESS is waiting on memory.
    run_op("pre_rst", 1, 0, 3'b010, 32'h500, 32'h0, 32'h5A5A5A5A, 0, 0, 32'h5A5A5A5A,
           32'h500, 4'h0, 32'h0);
    MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h600;
    mem_ready = 0;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (mem_req) seen = 1;
      end
      chk("rst_mid reached_access", seen, 1);
    end
    reset = 1;
    #1;
    chk("rst_mid mem_req", mem_req, 0);
    chk("rst_mid mem_we", mem_we, 0);
    clear_inputs();
    #1;
    chk("rst_mid stall", StallM, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("post_rst stall", StallM, 0);
    chk("post_rst ReadDataM", ReadDataM, 0);
    chk("post_rst mem_req", mem_req, 0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the RV32I pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register, and drives a word-wide data-memory port using a req/ready handshake.
- Aligns and sign- or zero-extends load data into ReadDataM.
- Generates byte strobes for stores.
- Stalls the pipeline while an access is outstanding.
- Flags misaligned or illegal accesses instead of issuing them.

Parameters:
- ADDR_W, 32, width of the byte address presented on mem_addr.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous reset, active-high
- MemReadM  in  1  instruction in MEM is a load
- MemWriteM  in  1  instruction in MEM is a store
- Funct3M  in  3  load/store size and sign-extension code
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store data (rs2)
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] forced to 0)
- mem_wdata  out  32  store data, lane-replicated
- mem_wstrb  out  4  byte-write strobes
- mem_rdata  in  32  read word; valid while mem_ready=1
- mem_ready  in  1  memory completes the request this cycle
- ReadDataM  out  32  formatted load result, sent to MEM/WB
- StallM  out  1  hold IF..MEM stages
- FaultM  out  1  misaligned or illegal access (one cycle per instruction)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - mem_req, mem_we = 0; mem_wstrb = 0; mem_addr, mem_wdata = 0.
  - ReadDataM = 0.
  - StallM and FaultM are combinational and evaluate to 0 in IDLE with no access.
- Access definition: access = MemReadM | MemWriteM.
- Fault condition:
  - MemReadM & MemWriteM both set, or
  - Funct3 is illegal: load 011/110/111, store other than 000/001/010, or
  - Halfword with addr[0] ≠ 0, or
  - Word with addr[1:0] ≠ 0.
- State machine has three states: IDLE, ACCESS, DONE.
- IDLE:
  - access & !fault: StallM = 1. Latch write/read, Funct3, address, formatted wdata and strobes into request registers, then go to ACCESS.
  - access & fault: FaultM = 1, StallM = 0, no request issued, stay in IDLE.
  - No access: no action.
- ACCESS:
  - mem_req = 1 and StallM = 1.
  - All mem_* outputs are driven from the request registers and stay stable until mem_ready.
  - On mem_ready (checked only in ACCESS), for a load: ReadDataM is loaded with the formatted mem_rdata using the latched Funct3 and addr[1:0]. Then go to DONE.
  - mem_ready outside ACCESS is ignored.
- DONE:
  - StallM = 0, mem_req = 0, ReadDataM holds its value, so the pipeline advances at the end of this cycle.
  - Always go to IDLE.
  - DONE never re-evaluates the MEM inputs. This prevents re-issuing the same instruction.
- Latency: minimum 3 cycles per access (IDLE detect, ACCESS with ready, DONE). Each wait cycle adds one ACCESS cycle.
- Load formatting (lane = addr[1:0]):
  - LB/LBU select byte[lane], sign- or zero-extended.
  - LH/LHU select half[addr[1]], sign- or zero-extended.
  - LW passes the word unchanged.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << lane.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << lane.
  - SW: wdata = rs2, wstrb = 1111.
  - Loads drive wstrb = 0000.
- ReadDataM is not updated by stores, faults or idle cycles.
- Reset mid-ACCESS: mem_req drops immediately (asynchronously) and the request is abandoned. Memory must tolerate this.
- No internal flush input. The pipeline must not flush MEM while StallM = 1.

Decomposition:
- Shared package riscv_pkg:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_state_t enum: IDLE, ACCESS, DONE.
- Sub-module load_align: combinational mapping of (rdata, funct3, lane) to the 32-bit result. It is reused by any future cache refill path.
- Store formatting and fault detection stay inline.

Test Plan:
- LW: addr 0x100, mem_ready after 2 wait cycles, rdata = 0xDEADBEEF. Expect StallM high for 4 cycles and ReadDataM = 0xDEADBEEF in DONE.
- LB/LBU: addr 0x103, rdata = 0x80FF_1234. Expect LB → 0xFFFFFF80 and LBU → 0x00000080.
- SH: addr 0x202, rs2 = 0xAAAA5678. Expect mem_addr = 0x200, wstrb = 1100, wdata = 0x56785678, mem_we = 1, ReadDataM unchanged.
- LW at 0x101 and SH at 0x203: expect FaultM = 1 for one cycle, StallM = 0, mem_req never asserted. Illegal load Funct3 = 011: same response.
- Back-to-back SW then LW: second request issues only after DONE→IDLE. Expect exactly one mem_req rising edge per instruction.
- Assert reset in ACCESS with mem_ready = 0: expect mem_req = 0 and state IDLE immediately. After deassert with no access: StallM = 0 and ReadDataM = 0.
